// File: rtl/sram_pkg.sv
// Shared types and constants for the memory-stage SRAM controller.
package sram_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LO,
        HI,
        WAIT,
        DONE
    } state_e;

    localparam int          SRAM_AW         = 18;
    localparam int          SRAM_DW         = 16;
    localparam logic [31:0] ADDR_OFFSET_DEF = 32'd1024;
    localparam int          WAIT_CYCLES_DEF = 3;

endpackage

// File: rtl/sram_mem_ctrl.sv
// Memory-stage responder: splits each 32-bit load/store into two
// 16-bit SRAM accesses plus a fixed wait, stalling via ready.
module sram_mem_ctrl #(
    parameter logic [31:0] ADDR_OFFSET = sram_pkg::ADDR_OFFSET_DEF,
    parameter int          WAIT_CYCLES = sram_pkg::WAIT_CYCLES_DEF,
    parameter int          SRAM_AW     = sram_pkg::SRAM_AW,
    parameter int          SRAM_DW     = sram_pkg::SRAM_DW
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mem_r_en,
    input  logic               mem_w_en,
    input  logic [31:0]        address,
    input  logic [31:0]        write_data,
    output logic [31:0]        read_data,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic               sram_we_n,
    output logic [SRAM_DW-1:0] sram_dq_out,
    output logic               sram_dq_oe,
    input  logic [SRAM_DW-1:0] sram_dq_in
);
    import sram_pkg::*;

    state_e             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [SRAM_AW-2:0] waddr_q, waddr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               wr_q, wr_d;
    logic [31:0]        offs;

    assign offs      = address - ADDR_OFFSET;
    assign read_data = rdata_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        wr_d        = wr_q;
        ready       = 1'b0;
        sram_addr   = '0;
        sram_we_n   = 1'b1;
        sram_dq_out = '0;
        sram_dq_oe  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (mem_w_en || mem_r_en) begin
                    wr_d    = mem_w_en;
                    waddr_d = offs[SRAM_AW:2];
                    wdata_d = write_data;
                    state_d = LO;
                end else begin
                    ready = 1'b1;
                end
            end
            LO: begin
                sram_addr = {waddr_q, 1'b0};
                if (wr_q) begin
                    sram_we_n   = 1'b0;
                    sram_dq_oe  = 1'b1;
                    sram_dq_out = wdata_q[15:0];
                end else begin
                    rdata_d[15:0] = sram_dq_in;
                end
                state_d = HI;
            end
            HI: begin
                sram_addr = {waddr_q, 1'b1};
                if (wr_q) begin
                    sram_we_n   = 1'b0;
                    sram_dq_oe  = 1'b1;
                    sram_dq_out = wdata_q[31:16];
                end else begin
                    rdata_d[31:16] = sram_dq_in;
                end
                cnt_d   = '0;
                state_d = (WAIT_CYCLES == 0) ? DONE : WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'(WAIT_CYCLES - 1)) state_d = DONE;
            end
            DONE: begin
                ready   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Never strobe the SRAM while reset is asserted
        if (rst) begin
            sram_addr   = '0;
            sram_we_n   = 1'b1;
            sram_dq_out = '0;
            sram_dq_oe  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            wr_q    <= wr_d;
        end
    end

endmodule

// File: tb/tb_sram_mem_ctrl.sv
// Self-checking bench for sram_mem_ctrl: SRAM device model, a
// cycle-offset reference model and directed plus random accesses.
module tb_sram_mem_ctrl;

    localparam int          W    = 3;
    localparam int          LAST = 3 + W;
    localparam logic [31:0] OFF  = 32'd1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_r_en, mem_w_en;
    logic [31:0] address, write_data, read_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic        sram_we_n;
    logic [15:0] sram_dq_out;
    logic        sram_dq_oe;
    logic [15:0] sram_dq_in;

    always #5 clk = ~clk;

    sram_mem_ctrl #(
        .ADDR_OFFSET(OFF),
        .WAIT_CYCLES(W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_r_en   (mem_r_en),
        .mem_w_en   (mem_w_en),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .ready      (ready),
        .sram_addr  (sram_addr),
        .sram_we_n  (sram_we_n),
        .sram_dq_out(sram_dq_out),
        .sram_dq_oe (sram_dq_oe),
        .sram_dq_in (sram_dq_in)
    );

    logic [15:0] sram_mem [0:262143];
    logic [15:0] refm     [0:262143];

    assign sram_dq_in = sram_mem[sram_addr];

    always @(posedge clk)
        if (!sram_we_n) sram_mem[sram_addr] <= sram_dq_out;

    int ncmp = 0;
    int nerr = 0;
    bit chk_en = 0;

    function automatic void cmp(string nm, logic [31:0] act,
                                logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t",
                     nm, act, exp, $time);
        end
    endfunction

    function automatic logic [16:0] wa_of(input logic [31:0] a);
        logic [31:0] d;
        d = a - OFF;
        return d[18:2];
    endfunction

    // Reference: m_k is the cycle offset inside an accepted access
    bit          m_busy = 0;
    int          m_k    = 0;
    bit          m_wr   = 0;
    logic [16:0] m_wa   = '0;
    logic [31:0] m_wd   = '0;
    logic [31:0] m_rd   = '0;

    always @(negedge clk) begin
        logic acc, hi;
        hi  = (m_k == 2);
        acc = m_busy && (m_k == 1 || m_k == 2) && !rst;
        if (chk_en) begin
            cmp("ready", 32'(ready),
                32'(m_busy ? (m_k == LAST) : !(mem_r_en || mem_w_en)));
            cmp("sram_addr", 32'(sram_addr),
                acc ? 32'({m_wa, hi}) : 32'd0);
            cmp("we_n", 32'(sram_we_n), 32'(!(acc && m_wr)));
            cmp("oe", 32'(sram_dq_oe), 32'(acc && m_wr));
            if (!(acc && !m_wr))
                cmp("dq_out", 32'(sram_dq_out),
                    (acc && m_wr) ? 32'(hi ? m_wd[31:16] : m_wd[15:0])
                                  : 32'd0);
            if (!m_busy || m_k == LAST)
                cmp("read_data", read_data, m_rd);
        end
        if (rst) begin
            m_busy = 0;
            m_rd   = '0;
        end else if (m_busy) begin
            if (m_k == 1 && m_wr) refm[{m_wa, 1'b0}] = m_wd[15:0];
            if (m_k == 2) begin
                if (m_wr) refm[{m_wa, 1'b1}] = m_wd[31:16];
                else m_rd = {refm[{m_wa, 1'b1}], refm[{m_wa, 1'b0}]};
            end
            if (m_k == LAST) m_busy = 0;
            else m_k++;
        end else if (mem_r_en || mem_w_en) begin
            m_busy = 1;
            m_k    = 1;
            m_wr   = mem_w_en;
            m_wa   = wa_of(address);
            m_wd   = write_data;
        end
    end

    task automatic do_access(input logic w, input logic r,
                             input logic [31:0] a, input logic [31:0] d,
                             input bit jit, output int n,
                             output logic [31:0] alo, output logic [31:0] ahi,
                             output logic [31:0] dlo, output logic [31:0] dhi,
                             output logic [31:0] rd);
        bit done;
        mem_w_en   = w;
        mem_r_en   = r;
        address    = a;
        write_data = d;
        n = 0; alo = '0; ahi = '0; dlo = '0; dhi = '0; rd = '0;
        done = 0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (ready) begin
                rd   = read_data;
                done = 1;
            end else begin
                n++;
                if (c == 1) begin alo = 32'(sram_addr); dlo = 32'(sram_dq_out); end
                if (c == 2) begin ahi = 32'(sram_addr); dhi = 32'(sram_dq_out); end
                if (jit && (c == 1 || c == 3)) begin
                    mem_w_en   = 1'($urandom);
                    mem_r_en   = 1'($urandom);
                    address    = $urandom;
                    write_data = $urandom;
                end
            end
        end
        if (!done) cmp("timeout_ready", 32'(ready), 32'd1);
        @(posedge clk);
        #1;
        mem_w_en = 1'b0;
        mem_r_en = 1'b0;
    endtask

    initial begin
        int n;
        logic [31:0] alo, ahi, dlo, dhi, rd, a;
        int op;
        rst = 1'b1;
        mem_r_en = 1'b0;
        mem_w_en = 1'b0;
        address = '0;
        write_data = '0;
        for (int i = 0; i < 262144; i++) begin
            sram_mem[i] = '0;
            refm[i]     = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b0;
        chk_en = 1;

        @(negedge clk);
        cmp("rst_ready", 32'(ready), 32'd1);
        cmp("rst_rdata", read_data, 32'd0);
        repeat (10) begin
            @(negedge clk);
            cmp("idle_ready", 32'(ready), 32'd1);
            cmp("idle_we_n", 32'(sram_we_n), 32'd1);
            cmp("idle_oe", 32'(sram_dq_oe), 32'd0);
        end
        @(posedge clk);
        #1;

        do_access(1, 0, 32'd1024, 32'hDEADBEEF, 0, n, alo, ahi, dlo, dhi, rd);
        cmp("st_busy", 32'(n), 32'd6);
        cmp("st_addr_lo", alo, 32'd0);
        cmp("st_data_lo", dlo, 32'h0000BEEF);
        cmp("st_addr_hi", ahi, 32'd1);
        cmp("st_data_hi", dhi, 32'h0000DEAD);
        do_access(0, 1, 32'd1024, 32'd0, 0, n, alo, ahi, dlo, dhi, rd);
        cmp("ld_busy", 32'(n), 32'd6);
        cmp("ld_data", rd, 32'hDEADBEEF);

        do_access(1, 0, 32'd1032, 32'h12345678, 0, n, alo, ahi, dlo, dhi, rd);
        cmp("map_addr_lo", alo, 32'd4);
        cmp("map_addr_hi", ahi, 32'd5);
        do_access(0, 1, 32'd1032, 32'd0, 0, n, alo, ahi, dlo, dhi, rd);
        cmp("b2b_busy", 32'(n), 32'd6);
        cmp("b2b_data", rd, 32'h12345678);

        do_access(1, 1, 32'd1028, 32'hA5A55A5A, 0, n, alo, ahi, dlo, dhi, rd);
        cmp("cfl_addr_lo", alo, 32'd2);
        cmp("cfl_addr_hi", ahi, 32'd3);
        cmp("cfl_rdata", rd, 32'h12345678);
        do_access(0, 1, 32'd1028, 32'd0, 0, n, alo, ahi, dlo, dhi, rd);
        cmp("cfl_load", rd, 32'hA5A55A5A);

        address    = 32'd1040;
        write_data = 32'h11112222;
        mem_w_en   = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        cmp("rsthi_we_n", 32'(sram_we_n), 32'd1);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        mem_w_en = 1'b0;
        @(negedge clk);
        cmp("rst_mid_ready", 32'(ready), 32'd1);
        cmp("rst_mid_rdata", read_data, 32'd0);
        cmp("rst_mid_we_n", 32'(sram_we_n), 32'd1);
        cmp("rst_mid_oe", 32'(sram_dq_oe), 32'd0);
        cmp("rst_mid_lo", 32'(sram_mem[8]), 32'h00002222);
        cmp("rst_mid_hi", 32'(sram_mem[9]), 32'd0);
        @(posedge clk);
        #1;
        do_access(0, 1, 32'd1040, 32'd0, 0, n, alo, ahi, dlo, dhi, rd);
        cmp("rst_mid_load", rd, 32'h00002222);

        repeat (80) begin
            op = $urandom_range(0, 3);
            a  = ($urandom_range(0, 3) == 0) ? $urandom
                                             : OFF + $urandom_range(0, 127);
            if (op == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end else begin
                do_access(op != 2, op != 1, a, $urandom, 1,
                          n, alo, ahi, dlo, dhi, rd);
                cmp("rnd_busy", 32'(n), 32'(LAST));
            end
        end

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 ncmp, nerr);
        $finish;
    end

endmodule
